sync_dualram_param: RTL
=======================

Name: sync_dualram_param

Overview:
Parametrised synchronous dual-port RAM (one write port, one read port) that generalises the team's fixed 16x8 asynchronous dual RAM.
- Adds per-byte write enables, a registered read with a valid strobe, and deterministic write-first collision handling.
- Adds a self-clearing init sweep after reset.
- Used as the generic buffer RAM under FIFOs and line buffers in the sequential-logic library.

Parameters:
DATA_WIDTH, 16, data word width; must be a multiple of 8
ADDR_WIDTH, 4, address width
DEPTH, 16, number of words; must be <= 2**ADDR_WIDTH
BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived; not overridden)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
cs  input  1  chip select; gates both ports
wr_enb  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_be  input  BE_WIDTH  byte enables; bit i covers wr_data[8i+7:8i]
rd_enb  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  registered read data
rd_valid  output  1  one-cycle strobe; rd_data is valid
ready  output  1  high once init sweep is done; requests are accepted only when high

Behaviour:
- Reset (rst=1 at an edge):
  - rd_data=0, rd_valid=0, ready=0.
  - FSM goes to INIT; init counter=0.
  - Memory contents are not reset directly.
- INIT:
  - Each cycle: mem[cnt]=0, cnt++.
  - At cnt==DEPTH-1, the clear completes; the next state is RUN and ready=1 from the following cycle.
  - INIT therefore lasts exactly DEPTH cycles after rst deasserts.
  - All wr_enb/rd_enb activity is ignored; rd_valid stays 0.
- RUN:
  - Write: when cs&wr_enb, mem[wr_addr] byte lane i is updated where wr_be[i]=1; other lanes keep their value.
  - Read: when cs&rd_enb, rd_data=mem[rd_addr] on the next edge (latency 1) and rd_valid=1 for that one cycle.
  - With no read, rd_data holds its last value and rd_valid=0.
- cs=0: no write, no read, rd_valid=0 next cycle.
- Collision (write and read same address, same cycle): write-first.
  - rd_data = lanes with wr_be=1 taken from wr_data, remaining lanes from old memory.
- Out-of-range address (>= DEPTH): write dropped; read returns 0 with rd_valid=1.
- Simultaneous read and write at different addresses: both complete independently.
- Reset mid-operation:
  - Any in-flight read is dropped (rd_valid=0).
  - The FSM restarts INIT; memory is fully re-cleared.
- States: INIT -> RUN (after the sweep). Any state -> INIT on rst. There is no other transition.

Optional Feature:
SYNC_DUALRAM_OUTREG_EN
- Defined:
  - An extra output register stage is added; read latency becomes 2.
  - rd_valid is pipelined alongside the data.
  - The collision merge is resolved at the request cycle.
  - Reset clears both stages.
- Undefined: read latency is 1, as described above.

Decomposition:
- Package sync_dualram_pkg:
  - default width/depth constants;
  - state typedef {INIT, RUN};
  - a function computing the byte-enable merge, shared by the write path and the collision bypass.
- Sub-module sync_dualram_init_ctrl: the INIT/RUN FSM plus the clear counter. It outputs ready, init_we and init_addr to the top level, which muxes them onto the write port.

Test Plan:
- Init sweep: pulse rst for 1 cycle -> ready=0 for exactly 16 cycles, then 1; reading every address 0..15 returns 0x0000.
- Write/read: write 0xA5C3 to addr 3 with be=2'b11, then read addr 3 -> rd_data=0xA5C3 one cycle later; rd_valid is high for 1 cycle only.
- Byte enables: mem[5]=0x1234; write 0xABCD with be=2'b01 -> read returns 0x12CD.
- Collision: mem[7]=0x1111; same cycle write 0x2222 be=2'b10 and read addr 7 -> rd_data=0x2211; a later read returns 0x2211.
- Gating: cs=0 with wr_enb=1 (addr 2, 0xFFFF) and rd_enb=1 -> mem[2] unchanged and rd_valid=0. Requests during INIT are ignored likewise.
- Reset mid-read: issue a read, assert rst the same cycle -> rd_valid=0 and rd_data=0; a previously written nonzero location reads 0 after ready returns.

Source files
------------

// File: rtl/sync_dualram_pkg.sv
// Shared types, default sizes and the byte-lane merge helper for sync_dualram_param.
package sync_dualram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_DEPTH      = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // One byte lane of a byte-enable merge; used by both the write path and the read bypass.
    function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sync_dualram_init_ctrl.sv
// INIT/RUN sequencer: sweeps a zero write across every word after reset, then raises ready.
module sync_dualram_init_ctrl
    import sync_dualram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready_o,
    output logic                  init_we_o,
    output logic [ADDR_WIDTH-1:0] init_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  ready_q;
    logic                  init_we_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            init_we_q <= 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        ready_q   <= 1'b1;
                        init_we_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    ready_q   <= 1'b1;
                    init_we_q <= 1'b0;
                end
                default: begin
                    state_q   <= INIT;
                    cnt_q     <= '0;
                    ready_q   <= 1'b0;
                    init_we_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign init_we_o   = init_we_q;
    assign init_addr_o = cnt_q;

endmodule

// File: rtl/sync_dualram_param.sv
// Synchronous 1W/1R RAM with byte enables, write-first collision bypass and post-reset clear sweep.
// Define SYNC_DUALRAM_OUTREG_EN to add a second output register stage (read latency 2).
module sync_dualram_param
    import sync_dualram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    wr_enb,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_enb,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    ready
);

    localparam int                  BE_WIDTH  = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  ctrl_ready;
    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;

    sync_dualram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_init_ctrl (
        .clk         (clk),
        .rst         (rst),
        .ready_o     (ctrl_ready),
        .init_we_o   (init_we),
        .init_addr_o (init_addr)
    );

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic wr_in_range, rd_in_range, wr_go, rd_go;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
    assign wr_go       = ctrl_ready & cs & wr_enb & wr_in_range;
    assign rd_go       = ctrl_ready & cs & rd_enb;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BE_WIDTH-1:0]   mem_wbe;
    logic [DATA_WIDTH-1:0] mem_old;
    logic [DATA_WIDTH-1:0] mem_wword;

    // The clear sweep owns the write port during INIT; user writes only reach it once ready.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
        mem_wword = '0;
        if (init_we) begin
            mem_we    = 1'b1;
            mem_waddr = init_addr;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else if (wr_go) begin
            mem_we = 1'b1;
        end
        mem_old = mem_q[mem_waddr];
        for (int i = 0; i < BE_WIDTH; i++) begin
            mem_wword[8*i +: 8] = be_merge(mem_old[8*i +: 8], mem_wdata[8*i +: 8], mem_wbe[i]);
        end
    end

    // NOTE: the array has no reset; the INIT sweep clears it so it can map onto RAM macros.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wword;
        end
    end

    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Write-first: a same-address write in this cycle is merged into the returned word.
    always_comb begin
        rd_old    = mem_q[rd_addr];
        rd_data_d = '0;
        if (rd_in_range) begin
            if (wr_go && (wr_addr == rd_addr)) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    rd_data_d[8*i +: 8] = be_merge(rd_old[8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
                end
            end else begin
                rd_data_d = rd_old;
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_go;
            if (rd_go) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

`ifdef SYNC_DUALRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] rd_data2_q;
    logic                  rd_valid2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data2_q  <= '0;
            rd_valid2_q <= 1'b0;
        end else begin
            rd_valid2_q <= rd_valid_q;
            if (rd_valid_q) begin
                rd_data2_q <= rd_data_q;
            end
        end
    end

    assign rd_data  = rd_data2_q;
    assign rd_valid = rd_valid2_q;
`else
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign ready = ctrl_ready;

endmodule
